rgb_pixel_pipe: RTL

//  Parametrised, pipelined per-pixel colour processor for the camera->VGA path. It sits between the

---
 rtl/rgb_pixel_pipe_pkg.sv | 20 ++
 rtl/rgb_luma.sv | 40 ++++
 rtl/rgb_pixel_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pixel_pipe_pkg.sv
// Shared constants for the RGB pixel pipeline and its luma sub-block.
package rgb_pixel_pipe_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PASS = 2'd0;
    localparam mode_t MODE_GRAY = 2'd1;
    localparam mode_t MODE_THR  = 2'd2;
    localparam mode_t MODE_INV  = 2'd3;

    // Integer luma weights, sum to 255 so Y never reaches 2^DW-1
    localparam int LUMA_R     = 54;
    localparam int LUMA_G     = 183;
    localparam int LUMA_B     = 18;
    localparam int LUMA_SHIFT = 8;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

endpackage

// File: rtl/rgb_luma.sv
// Registered luma: Y = (54*R + 183*G + 18*B) >> 8, one cycle of latency.
module rgb_luma
    import rgb_pixel_pipe_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [DW-1:0] r_i,
    input  logic [DW-1:0] g_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o
);

    logic [DW+7:0] prod_r, prod_g, prod_b;
    logic [DW+9:0] sum;
    logic [DW-1:0] y_d, y_q;
    logic          unused_sum_bits;

    // Weighted sum wide enough that no product or partial sum overflows
    always_comb begin
        prod_r = (DW+8)'(r_i) * (DW+8)'(LUMA_R);
        prod_g = (DW+8)'(g_i) * (DW+8)'(LUMA_G);
        prod_b = (DW+8)'(b_i) * (DW+8)'(LUMA_B);
        sum    = (DW+10)'(prod_r) + (DW+10)'(prod_g) + (DW+10)'(prod_b);
        y_d    = sum[LUMA_SHIFT +: DW];
    end

    // Fraction bits and the always-zero top bits are dropped on purpose
    assign unused_sum_bits = ^{sum[DW+9:DW+LUMA_SHIFT], sum[LUMA_SHIFT-1:0]};

    // Luma register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) y_q <= '0;
        else          y_q <= y_d;
    end

    assign y_o = y_q;

endmodule

// File: rtl/rgb_pixel_pipe.sv
// Three-stage per-pixel colour processor with window blanking, frame-stable
// mode/threshold and a per-frame bright-pixel count.
module rgb_pixel_pipe
    import rgb_pixel_pipe_pkg::*;
#(
    parameter int DW       = 8,
    parameter int CW       = 13,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int CNT_W    = 20
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             i_valid,
    input  logic [DW-1:0]    i_R,
    input  logic [DW-1:0]    i_G,
    input  logic [DW-1:0]    i_B,
    input  logic [CW-1:0]    i_row,
    input  logic [CW-1:0]    i_col,
    input  logic [1:0]       i_mode,
    input  logic [DW-1:0]    i_thresh,
    output logic             o_valid,
    output logic [DW-1:0]    o_R,
    output logic [DW-1:0]    o_G,
    output logic [DW-1:0]    o_B,
    output logic [CNT_W-1:0] o_bright_cnt,
    output logic             o_stat_valid
);

    localparam logic [CW-1:0] H_LIM  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_LIM  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE - 1);

    logic          sof_in, eof_in, win_in;
    mode_t         eff_mode;
    logic [DW-1:0] eff_thr;

    mode_t         shadow_mode_q;
    logic [DW-1:0] shadow_thr_q;

    logic          s1_valid_q, s1_win_q, s1_sof_q, s1_eof_q;
    logic [DW-1:0] s1_r_q, s1_g_q, s1_b_q, s1_thr_q;
    mode_t         s1_mode_q;

    logic          s2_valid_q, s2_win_q, s2_sof_q, s2_eof_q;
    logic [DW-1:0] s2_r_q, s2_g_q, s2_b_q, s2_thr_q, s2_y;
    mode_t         s2_mode_q;

    logic [DW-1:0] px_r_d, px_g_d, px_b_d;
    logic          out_valid_q;
    logic [DW-1:0] out_r_q, out_g_q, out_b_q;

    logic             hit, armed_now, publish;
    logic [CNT_W-1:0] cnt_base, cnt_sum;
    logic [CNT_W-1:0] cnt_q, bright_q;
    logic             armed_q, stat_valid_q;

    // Input decode; a sof pixel uses its own mode/thresh, later pixels the shadow copy
    always_comb begin
        sof_in   = i_valid && (i_row == '0) && (i_col == '0);
        eof_in   = i_valid && (i_row == V_LAST) && (i_col == H_LAST);
        win_in   = (i_row < V_LIM) && (i_col < H_LIM);
        eff_mode = sof_in ? mode_t'(i_mode) : shadow_mode_q;
        eff_thr  = sof_in ? i_thresh : shadow_thr_q;
    end

    // Frame-stable shadow registers, only a valid sof pixel reloads them
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            shadow_mode_q <= MODE_PASS;
            shadow_thr_q  <= '0;
        end else if (sof_in) begin
            shadow_mode_q <= mode_t'(i_mode);
            shadow_thr_q  <= i_thresh;
        end
    end

    // S1: capture pixel and per-pixel control; mode/thresh travel with the pixel
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_valid_q <= 1'b0;
            s1_win_q   <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            s1_r_q     <= '0;
            s1_g_q     <= '0;
            s1_b_q     <= '0;
            s1_mode_q  <= MODE_PASS;
            s1_thr_q   <= '0;
        end else begin
            s1_valid_q <= i_valid;
            s1_win_q   <= win_in;
            s1_sof_q   <= sof_in;
            s1_eof_q   <= eof_in;
            s1_r_q     <= i_R;
            s1_g_q     <= i_G;
            s1_b_q     <= i_B;
            s1_mode_q  <= eff_mode;
            s1_thr_q   <= eff_thr;
        end
    end

    rgb_luma #(.DW(DW)) u_luma (
        .clk_i   (iCLK),
        .rst_n_i (iRST_N),
        .r_i     (s1_r_q),
        .g_i     (s1_g_q),
        .b_i     (s1_b_q),
        .y_o     (s2_y)
    );

    // S2: delay line alongside the luma register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            s2_valid_q <= 1'b0;
            s2_win_q   <= 1'b0;
            s2_sof_q   <= 1'b0;
            s2_eof_q   <= 1'b0;
            s2_r_q     <= '0;
            s2_g_q     <= '0;
            s2_b_q     <= '0;
            s2_mode_q  <= MODE_PASS;
            s2_thr_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_win_q   <= s1_win_q;
            s2_sof_q   <= s1_sof_q;
            s2_eof_q   <= s1_eof_q;
            s2_r_q     <= s1_r_q;
            s2_g_q     <= s1_g_q;
            s2_b_q     <= s1_b_q;
            s2_mode_q  <= s1_mode_q;
            s2_thr_q   <= s1_thr_q;
        end
    end

    // S3 mode mux; pixels outside the window are blanked in every mode
    always_comb begin
        px_r_d = '0;
        px_g_d = '0;
        px_b_d = '0;
        if (s2_win_q) begin
            unique case (s2_mode_q)
                MODE_PASS: begin px_r_d = s2_r_q; px_g_d = s2_g_q; px_b_d = s2_b_q; end
                MODE_GRAY: begin px_r_d = s2_y;   px_g_d = s2_y;   px_b_d = s2_y;   end
                MODE_THR: begin
                    px_r_d = (s2_y >= s2_thr_q) ? '1 : '0;
                    px_g_d = px_r_d;
                    px_b_d = px_r_d;
                end
                MODE_INV:  begin px_r_d = ~s2_r_q; px_g_d = ~s2_g_q; px_b_d = ~s2_b_q; end
            endcase
        end
    end

    // S3 output registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            out_g_q     <= '0;
            out_b_q     <= '0;
        end else begin
            out_valid_q <= s2_valid_q;
            out_r_q     <= px_r_d;
            out_g_q     <= px_g_d;
            out_b_q     <= px_b_d;
        end
    end

    // Statistic next-state: sof restarts the count, eof publishes only after a seen sof
    always_comb begin
        hit       = s2_valid_q && s2_win_q && (s2_y >= s2_thr_q);
        cnt_base  = s2_sof_q ? '0 : cnt_q;
        cnt_sum   = (hit && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
        armed_now = armed_q || s2_sof_q;
        publish   = s2_eof_q && armed_now;
    end

    // Bright-pixel counter and published result
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt_q        <= '0;
            bright_q     <= '0;
            armed_q      <= 1'b0;
            stat_valid_q <= 1'b0;
        end else if (publish) begin
            cnt_q        <= '0;
            bright_q     <= cnt_sum;
            armed_q      <= 1'b0;
            stat_valid_q <= 1'b1;
        end else begin
            cnt_q        <= cnt_sum;
            armed_q      <= armed_now;
            stat_valid_q <= 1'b0;
        end
    end

    assign o_valid      = out_valid_q;
    assign o_R          = out_r_q;
    assign o_G          = out_g_q;
    assign o_B          = out_b_q;
    assign o_bright_cnt = bright_q;
    assign o_stat_valid = stat_valid_q;

endmodule
